// File: rtl/div_if.sv
// Execute-stage divider interface: pipeline-side controls and operands in,
// stall/valid and HI/LO results out.
interface div_if #(
    parameter int WIDTH = 32
) ();
    logic             div_startE;
    logic             div_signedE;
    logic [WIDTH-1:0] opaE;
    logic [WIDTH-1:0] opbE;
    logic             stall_holdE;
    logic             flush_exceptionM;
    logic             div_stallE;
    logic             div_validE;
    logic [WIDTH-1:0] div_hiE;
    logic [WIDTH-1:0] div_loE;

    // Pipeline side: issues the divide, consumes the results
    modport master (
        output div_startE, div_signedE, opaE, opbE, stall_holdE, flush_exceptionM,
        input  div_stallE, div_validE, div_hiE, div_loE
    );

    // Divider side
    modport slave (
        input  div_startE, div_signedE, opaE, opbE, stall_holdE, flush_exceptionM,
        output div_stallE, div_validE, div_hiE, div_loE
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// One quotient bit per cycle on operand magnitudes; signs are applied when
// the last bit is produced. Holds the pipeline via div_stallE until done.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_if.slave     bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             abort;

    // Operand magnitudes and one restoring step of the datapath
    always_comb begin
        sign_a   = bus.div_signedE & bus.opaE[WIDTH-1];
        sign_b   = bus.div_signedE & bus.opbE[WIDTH-1];
        mag_a    = sign_a ? (~bus.opaE + WIDTH'(1)) : bus.opaE;
        mag_b    = sign_b ? (~bus.opbE + WIDTH'(1)) : bus.opbE;
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        qbit     = ~trial[WIDTH];
        rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {dvd_q[WIDTH-2:0], qbit};
        // A divide losing its instruction mid-flight is annulled like a flush
        abort    = bus.flush_exceptionM | ((state_q == BUSY) & ~bus.div_startE);
    end

    // Next-state and result computation
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        valid_d = valid_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (abort) begin
            // Results keep stale values; consumers gate them with div_validE
            state_d = IDLE;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.div_startE) begin
                        dvd_d   = mag_a;
                        dvs_d   = mag_b;
                        qsign_d = sign_a ^ sign_b;
                        rsign_d = sign_a;
                        rem_d   = '0;
                        count_d = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    rem_d   = rem_step;
                    dvd_d   = quo_step;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        lo_d    = qsign_q ? (~quo_step + WIDTH'(1)) : quo_step;
                        hi_d    = rsign_q ? (~rem_step + WIDTH'(1)) : rem_step;
                        valid_d = 1'b1;
                        count_d = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Stay put while E is held so the same instruction never restarts
                    if (!bus.stall_holdE) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            valid_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            valid_q <= valid_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.div_stallE = bus.div_startE & ~bus.flush_exceptionM &
                            ((state_q == IDLE) | (state_q == BUSY));
    assign bus.div_validE = valid_q;
    assign bus.div_hiE    = hi_q;
    assign bus.div_loE    = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, overflow, flush, hold in DONE, back-to-back and mid-divide reset.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    div_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue a divide in the next cycle (cycle 0) and follow it to completion.
    // Inputs stay asserted afterwards so the caller decides how E advances.
    task automatic start_and_wait(input string tag, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                                  input logic hold_at_done);
        int n;
        @(posedge clk); #1;
        dif.div_startE  = 1'b1;
        dif.div_signedE = sgn;
        dif.opaE        = a;
        dif.opbE        = b;
        dif.stall_holdE = 1'b0;
        n = 0;
        @(negedge clk);
        chk({tag, "_valid_c0"}, {31'd0, dif.div_validE}, 32'd0);
        while (dif.div_stallE && n < 40) begin
            n++;
            if (n == 1) dif.stall_holdE = hold_at_done;
            @(negedge clk);
        end
        chk({tag, "_stall_cycles"}, n, 32'd33);
        chk({tag, "_valid"}, {31'd0, dif.div_validE}, 32'd1);
        chk({tag, "_lo"}, dif.div_loE, exp_lo);
        chk({tag, "_hi"}, dif.div_hiE, exp_hi);
        $display("div %s: lo=0x%08h hi=0x%08h stall_cycles=%0d", tag, dif.div_loE, dif.div_hiE, n);
    endtask

    // E advances past the divide; next instruction is not a divide
    task automatic release_e(input string tag);
        @(posedge clk); #1;
        dif.div_startE  = 1'b0;
        dif.stall_holdE = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_after"}, {31'd0, dif.div_validE}, 32'd0);
        chk({tag, "_stall_after"}, {31'd0, dif.div_stallE}, 32'd0);
    endtask

    initial begin
        logic [31:0] held_lo;
        logic [31:0] held_hi;
        n_checks = 0;
        n_fail   = 0;
        rst                  = 1'b1;
        dif.div_startE       = 1'b0;
        dif.div_signedE      = 1'b0;
        dif.opaE             = '0;
        dif.opbE             = '0;
        dif.stall_holdE      = 1'b0;
        dif.flush_exceptionM = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, dif.div_validE}, 32'd0);
        chk("rst_stall", {31'd0, dif.div_stallE}, 32'd0);
        chk("rst_lo", dif.div_loE, 32'd0);
        chk("rst_hi", dif.div_hiE, 32'd0);

        // Basic unsigned and signed cases
        start_and_wait("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        release_e("divu_100_7");
        start_and_wait("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        release_e("div_m7_2");
        start_and_wait("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        release_e("div_7_m2");

        // Boundaries
        start_and_wait("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        release_e("divu_5_0");
        start_and_wait("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, 1'b0);
        release_e("div_m5_0");
        start_and_wait("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        release_e("div_5_0");
        start_and_wait("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        release_e("div_ovf");

        // Flush in cycle 10 of a divide
        @(posedge clk); #1;
        dif.div_startE  = 1'b1;
        dif.div_signedE = 1'b0;
        dif.opaE        = 32'd100;
        dif.opbE        = 32'd7;
        repeat (10) @(posedge clk);
        #1 dif.flush_exceptionM = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, dif.div_stallE}, 32'd0);
        @(posedge clk); #1;
        dif.flush_exceptionM = 1'b0;
        dif.div_startE       = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'd0, dif.div_validE}, 32'd0);
        chk("flush_idle_stall", {31'd0, dif.div_stallE}, 32'd0);
        start_and_wait("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        release_e("divu_9_3");

        // Hold in DONE for 5 cycles
        start_and_wait("hold", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        held_lo = dif.div_loE;
        held_hi = dif.div_hiE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, dif.div_validE}, 32'd1);
            chk("hold_stall", {31'd0, dif.div_stallE}, 32'd0);
            chk("hold_lo", dif.div_loE, 32'd14);
            chk("hold_hi", dif.div_hiE, 32'd2);
        end
        $display("hold: lo=0x%08h hi=0x%08h kept for 5 cycles", held_lo, held_hi);
        @(posedge clk); #1 dif.stall_holdE = 1'b0;
        @(negedge clk);
        chk("hold_rel_valid", {31'd0, dif.div_validE}, 32'd1);
        release_e("hold");

        // Back-to-back: second divide enters E the cycle after the first's DONE
        start_and_wait("b2b_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);
        start_and_wait("b2b_1_1", 1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0);
        release_e("b2b_1_1");

        // Reset in the middle of a divide
        @(posedge clk); #1;
        dif.div_startE  = 1'b1;
        dif.div_signedE = 1'b0;
        dif.opaE        = 32'd50;
        dif.opbE        = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        rst            = 1'b1;
        dif.div_startE = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, dif.div_validE}, 32'd0);
        chk("midrst_stall", {31'd0, dif.div_stallE}, 32'd0);
        chk("midrst_lo", dif.div_loE, 32'd0);
        chk("midrst_hi", dif.div_hiE, 32'd0);
        $display("mid-divide reset: valid=%0b lo=0x%08h hi=0x%08h", dif.div_validE, dif.div_loE, dif.div_hiE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
